// File: rtl/adder_result_checker.sv
// Response checker for parallel-prefix adders: aligns operands to the adder latency, compares {Cout,Sum}
// against A+B+Cin and counts passes/failures. Define ADDER_CHK_FIRST_FAIL_EN to capture the first failing vector.
module adder_result_checker #(
   parameter int OPERAND_SIZE = 16,
   parameter int DUT_LATENCY  = 0,
   parameter int NUM_VECTORS  = 100,
   parameter int CNT_WIDTH    = 16
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Start,
   input  logic                    In_Valid,
   input  logic [OPERAND_SIZE-1:0] A,
   input  logic [OPERAND_SIZE-1:0] B,
   input  logic                    Cin,
   input  logic [OPERAND_SIZE-1:0] Sum,
   input  logic                    Cout,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Error,
   output logic [CNT_WIDTH-1:0]    Vec_Count,
   output logic [CNT_WIDTH-1:0]    Pass_Count,
   output logic [CNT_WIDTH-1:0]    Fail_Count,
   output logic [OPERAND_SIZE-1:0] Fail_A,
   output logic [OPERAND_SIZE-1:0] Fail_B,
   output logic                    Fail_Cin,
   output logic [OPERAND_SIZE:0]   Fail_Got
);

   localparam int RW = OPERAND_SIZE + 1;
   localparam logic [CNT_WIDTH-1:0] LAST_VEC = CNT_WIDTH'(NUM_VECTORS - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                  state;
   logic                    vld_d;
   logic [OPERAND_SIZE-1:0] a_d;
   logic [OPERAND_SIZE-1:0] b_d;
   logic                    cin_d;
   logic [RW-1:0]           exp_sum;
   logic [RW-1:0]           got_sum;
   logic                    match;
   logic [CNT_WIDTH-1:0]    vec_cnt;
   logic [CNT_WIDTH-1:0]    pass_cnt;
   logic [CNT_WIDTH-1:0]    fail_cnt;
   logic                    error_q;
   logic                    check_en;
   logic                    clear_run;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [RW-1:0] golden_sum(input logic [OPERAND_SIZE-1:0] a,
                                                input logic [OPERAND_SIZE-1:0] b,
                                                input logic                    c);
      return RW'(a) + RW'(b) + RW'(c);
   endfunction

   // Stage p0..pN: operand alignment chain, shifts every cycle independent of the FSM
   generate
      if (DUT_LATENCY == 0) begin : g_direct
         assign vld_d = In_Valid;
         assign a_d   = A;
         assign b_d   = B;
         assign cin_d = Cin;
      end else begin : g_pipe
         logic                    vld_p [DUT_LATENCY];
         logic [OPERAND_SIZE-1:0] a_p   [DUT_LATENCY];
         logic [OPERAND_SIZE-1:0] b_p   [DUT_LATENCY];
         logic                    cin_p [DUT_LATENCY];

         always_ff @(posedge Clk) begin
            if (Rst) begin
               for (int i = 0; i < DUT_LATENCY; i++) vld_p[i] <= 1'b0;
            end else begin
               vld_p[0] <= In_Valid;
               for (int i = 1; i < DUT_LATENCY; i++) vld_p[i] <= vld_p[i-1];
            end
         end

         always_ff @(posedge Clk) begin
            a_p[0]   <= A;
            b_p[0]   <= B;
            cin_p[0] <= Cin;
            for (int i = 1; i < DUT_LATENCY; i++) begin
               a_p[i]   <= a_p[i-1];
               b_p[i]   <= b_p[i-1];
               cin_p[i] <= cin_p[i-1];
            end
         end

         assign vld_d = vld_p[DUT_LATENCY-1];
         assign a_d   = a_p[DUT_LATENCY-1];
         assign b_d   = b_p[DUT_LATENCY-1];
         assign cin_d = cin_p[DUT_LATENCY-1];
      end
   endgenerate

   // Compare stage: full-width check including carry-out
   assign exp_sum   = golden_sum(a_d, b_d, cin_d);
   assign got_sum   = {Cout, Sum};
   assign match     = (got_sum == exp_sum);
   assign check_en  = (state == S_RUN) && vld_d;
   assign clear_run = (state != S_RUN) && Start;

   // Count stage: run control and result counters
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state    <= S_IDLE;
         vec_cnt  <= '0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         error_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (Start) begin
                  state    <= S_RUN;
                  vec_cnt  <= '0;
                  pass_cnt <= '0;
                  fail_cnt <= '0;
                  error_q  <= 1'b0;
               end
            end
            S_RUN: begin
               if (vld_d) begin
                  vec_cnt <= vec_cnt + 1'b1;
                  if (match) begin
                     pass_cnt <= pass_cnt + 1'b1;
                  end else begin
                     fail_cnt <= sat_inc(fail_cnt);
                     error_q  <= 1'b1;
                  end
                  if (vec_cnt == LAST_VEC) state <= S_DONE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign Busy       = (state == S_RUN);
   assign Done       = (state == S_DONE);
   assign Error      = error_q;
   assign Vec_Count  = vec_cnt;
   assign Pass_Count = pass_cnt;
   assign Fail_Count = fail_cnt;

`ifdef ADDER_CHK_FIRST_FAIL_EN
   logic [OPERAND_SIZE-1:0] fail_a_q;
   logic [OPERAND_SIZE-1:0] fail_b_q;
   logic                    fail_cin_q;
   logic [RW-1:0]           fail_got_q;

   // error_q low means nothing has failed yet this run, so this is the first mismatch
   always_ff @(posedge Clk) begin
      if (Rst || clear_run) begin
         fail_a_q   <= '0;
         fail_b_q   <= '0;
         fail_cin_q <= 1'b0;
         fail_got_q <= '0;
      end else if (check_en && !match && !error_q) begin
         fail_a_q   <= a_d;
         fail_b_q   <= b_d;
         fail_cin_q <= cin_d;
         fail_got_q <= got_sum;
      end
   end

   assign Fail_A   = fail_a_q;
   assign Fail_B   = fail_b_q;
   assign Fail_Cin = fail_cin_q;
   assign Fail_Got = fail_got_q;
`else
   logic unused_cap;
   assign unused_cap = check_en ^ clear_run;
   assign Fail_A     = '0;
   assign Fail_B     = '0;
   assign Fail_Cin   = 1'b0;
   assign Fail_Got   = '0;
`endif

endmodule

// File: tb/tb_adder_result_checker.sv
// Randomized bench for adder_result_checker: an adder model with injectable faults drives Sum/Cout, and a
// vector-history reference model predicts every output each cycle.
module tb_adder_result_checker;

   localparam int LAT = 3;
   localparam int NV  = 10;
   localparam int OW  = 16;
   localparam int CW  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1, start = 1'b0, in_valid = 1'b0, cin = 1'b0, cout = 1'b0;
   logic [OW-1:0] a = '0, b = '0, sum = '0;
   logic          busy, done, error, fail_cin;
   logic [CW-1:0] vec_count, pass_count, fail_count;
   logic [OW-1:0] fail_a, fail_b;
   logic [OW:0]   fail_got;

   adder_result_checker #(
      .OPERAND_SIZE(OW), .DUT_LATENCY(LAT), .NUM_VECTORS(NV), .CNT_WIDTH(CW)
   ) dut (
      .Clk(clk), .Rst(rst), .Start(start), .In_Valid(in_valid), .A(a), .B(b), .Cin(cin),
      .Sum(sum), .Cout(cout), .Busy(busy), .Done(done), .Error(error),
      .Vec_Count(vec_count), .Pass_Count(pass_count), .Fail_Count(fail_count),
      .Fail_A(fail_a), .Fail_B(fail_b), .Fail_Cin(fail_cin), .Fail_Got(fail_got)
   );

   typedef struct packed {
      logic          v;
      logic [OW-1:0] a;
      logic [OW-1:0] b;
      logic          c;
      logic [OW:0]   got;
   } vec_t;

   vec_t drv_q [16];
   vec_t mdl_q [LAT];
   int   sum_delay = LAT;
   int   n_vec = 0, n_err = 0;

   int          m_mode;
   int          m_vec, m_pass, m_fail;
   logic [OW-1:0] m_fa, m_fb;
   logic          m_fc;
   logic [OW:0]   m_fg;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_vec = 0; m_pass = 0; m_fail = 0;
      m_fa = '0; m_fb = '0; m_fc = 1'b0; m_fg = '0;
   endtask

   task automatic model_edge();
      vec_t        al;
      logic [OW:0] got, expv;
      al   = mdl_q[LAT-1];
      got  = {cout, sum};
      expv = (OW+1)'(al.a) + (OW+1)'(al.b) + (OW+1)'(al.c);
      if (rst) begin
         m_mode = 0;
         model_clear();
      end else if (m_mode == 1) begin
         if (al.v) begin
            m_vec++;
            if (got == expv) m_pass++;
            else begin
`ifdef ADDER_CHK_FIRST_FAIL_EN
               if (m_fail == 0) begin
                  m_fa = al.a; m_fb = al.b; m_fc = al.c; m_fg = got;
               end
`endif
               if (m_fail < (1 << CW) - 1) m_fail++;
            end
            if (m_vec == NV) m_mode = 2;
         end
      end else if (start) begin
         m_mode = 1;
         model_clear();
      end
      for (int i = LAT-1; i > 0; i--) mdl_q[i] = mdl_q[i-1];
      mdl_q[0] = drv_q[0];
      if (rst) for (int i = 0; i < LAT; i++) mdl_q[i].v = 1'b0;
   endtask

   task automatic compare_all();
      chk("busy", 32'(busy), 32'(m_mode == 1));
      chk("done", 32'(done), 32'(m_mode == 2));
      chk("error", 32'(error), 32'(m_fail != 0));
      chk("vec_count", 32'(vec_count), 32'(m_vec));
      chk("pass_count", 32'(pass_count), 32'(m_pass));
      chk("fail_count", 32'(fail_count), 32'(m_fail));
      chk("fail_a", 32'(fail_a), 32'(m_fa));
      chk("fail_b", 32'(fail_b), 32'(m_fb));
      chk("fail_cin", 32'(fail_cin), 32'(m_fc));
      chk("fail_got", 32'(fail_got), 32'(m_fg));
   endtask

   task automatic cyc(input logic v, input logic [OW-1:0] av, input logic [OW-1:0] bv,
                      input logic cv, input logic bad, input logic [OW:0] badv);
      vec_t e;
      e.v = v; e.a = av; e.b = bv; e.c = cv;
      e.got = bad ? badv : ((OW+1)'(av) + (OW+1)'(bv) + (OW+1)'(cv));
      for (int i = 15; i > 0; i--) drv_q[i] = drv_q[i-1];
      drv_q[0] = e;
      in_valid = v; a = av; b = bv; cin = cv;
      {cout, sum} = drv_q[sum_delay].got;
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   function automatic logic [OW-1:0] pick();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return '1;
         2: return 16'h8000;
         default: return OW'($urandom);
      endcase
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, OW'($urandom), OW'($urandom), 1'b0, 1'b0, '0);
   endtask

   task automatic good(input logic v);
      cyc(v, pick(), pick(), 1'($urandom), 1'b0, '0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) drv_q[i] = '0;
      for (int i = 0; i < LAT; i++) mdl_q[i] = '0;
      m_mode = 0;
      model_clear();

      rst = 1'b1; idle(2); rst = 1'b0; idle(2);

      // all-pass run, back-to-back, in-flight vectors after DONE discarded
      start = 1'b1; cyc(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, '0); start = 1'b0;
      for (int i = 0; i < NV + 1; i++) good(1'b1);
      idle(LAT + 2);
      chk("allpass_done", 32'(done), 32'd1);
      chk("allpass_pass", 32'(pass_count), NV);
      chk("allpass_fail", 32'(fail_count), 32'd0);

      // restart from DONE with injected faults, gaps, and Start in RUN
      start = 1'b1; cyc(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1, 17'h05555); start = 1'b0;
      cyc(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, '0);
      cyc(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b1, 17'h00000);
      start = 1'b1; good(1'b1); start = 1'b0;
      for (int i = 0; i < 16; i++) good(1'(i % 2));
      idle(LAT + 2);
      chk("fault_error", 32'(error), 32'd1);
      chk("fault_count_ge2", 32'(fail_count >= 2), 32'd1);
`ifdef ADDER_CHK_FIRST_FAIL_EN
      chk("first_fail_a", 32'(fail_a), 32'h1234);
      chk("first_fail_b", 32'(fail_b), 32'h4321);
      chk("first_fail_cin", 32'(fail_cin), 32'd1);
      chk("first_fail_got", 32'(fail_got), 32'h05555);
`endif

      // adder latency one shorter than the checker expects
      sum_delay = LAT - 1;
      start = 1'b1; good(1'b1); start = 1'b0;
      for (int i = 0; i < NV + 2; i++) cyc(1'b1, OW'($urandom), OW'($urandom), 1'($urandom), 1'b0, '0);
      idle(LAT + 2);
      chk("misalign_fails", 32'(fail_count != 0), 32'd1);
      sum_delay = LAT;

      // reset in the middle of a run with vectors still in flight
      start = 1'b1; good(1'b1); start = 1'b0;
      for (int i = 0; i < 7; i++) good(1'b1);
      rst = 1'b1; good(1'b1); rst = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_vec", 32'(vec_count), 32'd0);
      for (int i = 0; i < 4; i++) good(1'b1);

      // random mix of starts, gaps, faults and occasional resets
      for (int i = 0; i < 400; i++) begin
         rst   = ($urandom_range(0, 99) == 0);
         start = ($urandom_range(0, 14) == 0);
         cyc(($urandom_range(0, 3) != 0), pick(), pick(), 1'($urandom),
             ($urandom_range(0, 11) == 0), (OW+1)'($urandom));
      end
      rst = 1'b0; start = 1'b0;
      idle(LAT + 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Self-checking response end for the parallel-prefix adders: receives each operand set plus the adder's Sum/Cout, computes the golden A+B+Cin, and counts passes and failures.
- Sits after the adder under test in on-chip BIST and in simulation benches. It consumes what the stimulus side drives and the adder produces.
- Compensates for a pipelined adder by delaying operands DUT_LATENCY cycles before comparison.

Parameters:
- OPERAND_SIZE, 16: width of A, B, Sum.
- DUT_LATENCY, 0: cycles between operands presented and Sum/Cout valid, range 0..8.
- NUM_VECTORS, 100: checks per run before Done; range 1..65535.
- CNT_WIDTH, 16: width of Vec_Count, Pass_Count, Fail_Count.

Ports:
- Clk  input  1  rising-edge clock.
- Rst  input  1  synchronous active-high reset.
- Start  input  1  pulse to clear counters and begin a run.
- In_Valid  input  1  A/B/Cin valid this cycle.
- A  input  OPERAND_SIZE  operand A.
- B  input  OPERAND_SIZE  operand B.
- Cin  input  1  carry in.
- Sum  input  OPERAND_SIZE  adder sum, valid DUT_LATENCY cycles after its operands.
- Cout  input  1  adder carry out, same timing as Sum.
- Busy  output  1  state is RUN.
- Done  output  1  state is DONE.
- Error  output  1  sticky: Fail_Count != 0.
- Vec_Count  output  CNT_WIDTH  checks performed this run.
- Pass_Count  output  CNT_WIDTH  matching checks.
- Fail_Count  output  CNT_WIDTH  mismatching checks, saturating.
- Fail_A, Fail_B  output  OPERAND_SIZE  operands of first failure (feature-dependent).
- Fail_Cin  output  1  Cin of first failure (feature-dependent).
- Fail_Got  output  OPERAND_SIZE+1  {Cout,Sum} observed at first failure (feature-dependent).

Behaviour:
- Reset:
  - State IDLE.
  - All counters, Error, Busy, Done, and Fail_* are 0.
  - Alignment pipeline valid bits are cleared. Data bits are don't-care.
  - Reset during RUN aborts the run; no partial results are kept.
- Alignment:
  - {In_Valid,A,B,Cin} pass through a DUT_LATENCY-deep register chain, shifting every cycle regardless of state.
  - DUT_LATENCY=0 means a direct wire.
  - The chain output is compared against the current Sum/Cout.
- Golden model:
  - Exp = A_d + B_d + Cin_d, computed at OPERAND_SIZE+1 bits.
  - Match when {Cout,Sum} == Exp. Every bit is compared, including carry-out.
- State machine:
  - IDLE: Start -> RUN. Counters and Fail_* clear on that edge.
  - RUN: each cycle with aligned valid=1:
    - Vec_Count+1.
    - Pass_Count+1 on match; otherwise Fail_Count+1, saturating at all-ones.
    - The check at Vec_Count==NUM_VECTORS-1 moves to DONE on the same edge.
    - Start is ignored in RUN.
  - DONE: counters hold. Start -> RUN with counters cleared (restart).
- Outputs are registered. Counts reflect a check one cycle after the aligned valid.
- Vectors whose aligned valid arrives while in IDLE/DONE are discarded and not counted, including in-flight vectors when the run ends.
- Start and aligned valid in the same IDLE cycle: that vector is not counted; counting begins the next cycle.
- Vec_Count == Pass_Count + Fail_Count, except after Fail_Count saturation.
- Error is set the cycle after the first mismatch and held until Start or Rst.

Optional Feature:
- Macro: ADDER_CHK_FIRST_FAIL_EN.
- Defined: on the first mismatch of a run, Fail_A, Fail_B, Fail_Cin, Fail_Got capture the aligned operands and observed {Cout,Sum}. They hold until Start or Rst; later failures do not overwrite them.
- Undefined: no capture registers. Fail_* are constant 0; ports remain present.

Test Plan:
- All-pass, DUT_LATENCY=0, NUM_VECTORS=4, correct combinational model: A=16'hFFFF, B=16'h0001, Cin=0 -> {Cout,Sum}=17'h10000 matches. Result: Done=1 after 4 checks, Pass_Count=4, Fail_Count=0, Error=0.
- Injected fault: vector A=16'h1234, B=16'h4321, Cin=1 fed Sum=16'h5555 (expected 16'h5556) -> Fail_Count=1, Error=1 next cycle. With the macro: Fail_A=16'h1234, Fail_B=16'h4321, Fail_Cin=1, Fail_Got=17'h05555.
- Carry-out check: A=16'h8000, B=16'h8000, Cin=0, Sum=16'h0000, Cout=0 -> counted as failure (carry-out is checked).
- Latency alignment: DUT_LATENCY=3, model delays sum 3 cycles, 10 back-to-back vectors -> Pass_Count=10, Fail_Count=0. Same stimulus with DUT_LATENCY=2 -> failures reported.
- Gaps and restart: In_Valid toggling 1,0,1 -> Vec_Count advances only on valid cycles. Start pulse in RUN ignored. Start in DONE -> all counts 0, Busy=1 next cycle.
- Reset mid-run: Rst asserted after 5 checks -> next cycle state IDLE, all counts 0, Busy=0, Done=0. Vectors in flight are discarded.
